// File: rtl/bitfusion_column_ctrl.sv
// bitfusion_column_ctrl
//   Sequencer for one BitFusion column (16-PE chain, weight buffers, accumulator).
//   It latches the per-job configuration and drives the column-wide controls
//   (state, input_bitwidth, sign_x/y, signal). It fetches the weights, then
//   issues cfg_num_vec input vectors, tolerating bubbles on in_valid. Issued
//   vectors are tracked through the fixed-latency column pipeline so that
//   out_valid and done line up with the column's total_output.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             job request, accepted only while IDLE
//   cfg_bitwidth      operand bitwidth (00 2b, 01 4b, 1x 8b)
//   cfg_sign_x/y      input / weight sign configuration
//   cfg_num_vec       vectors to issue (0 behaves as 1)
//   in_valid          input buffer holds a vector this cycle
//   in_rd             pop/issue strobe to the input buffer
//   w_rd              weight buffer read strobe (whole LOAD_W phase)
//   acc_clear         accumulator clear, one cycle on job acceptance
//   state             00 IDLE, 01 LOAD_W, 10 COMPUTE, 11 DRAIN
//   input_bitwidth    latched cfg_bitwidth
//   sign_x, sign_y    latched cfg_sign_x / cfg_sign_y
//   signal            SIG_* word selected by the latched bitwidth
//   out_valid         column output valid this cycle
//   busy              state != IDLE
//   done              pulse on the job's last out_valid

module bitfusion_column_ctrl #(
  parameter int          PIPE_DEPTH = 20,
  parameter int          WLOAD_CYC  = 2,
  parameter int          CNT_W      = 16,
  parameter logic [63:0] SIG_2B     = 64'h0,
  parameter logic [63:0] SIG_4B     = 64'h0,
  parameter logic [63:0] SIG_8B     = 64'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cfg_bitwidth,
  input  logic [3:0]       cfg_sign_x,
  input  logic [3:0]       cfg_sign_y,
  input  logic [CNT_W-1:0] cfg_num_vec,
  input  logic             in_valid,
  output logic             in_rd,
  output logic             w_rd,
  output logic             acc_clear,
  output logic [1:0]       state,
  output logic [1:0]       input_bitwidth,
  output logic [3:0]       sign_x,
  output logic [3:0]       sign_y,
  output logic [63:0]      signal,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_LOAD_W  = 2'b01,
    S_COMPUTE = 2'b10,
    S_DRAIN   = 2'b11
  } state_t;

  // Weight-load cycle counter only needs to reach WLOAD_CYC-1.
  localparam int              WC_W   = (WLOAD_CYC > 2) ? $clog2(WLOAD_CYC) : 1;
  localparam logic [WC_W-1:0] W_LAST = WC_W'(WLOAD_CYC - 1);

  state_t cur_state;
  state_t nxt_state;

  logic [1:0]            bw_q;
  logic [3:0]            sx_q;
  logic [3:0]            sy_q;
  // Index of the last vector (num_vec-1, with 0 folded to 1) so that the
  // issue and retire comparisons need no subtractor on the hot path.
  logic [CNT_W-1:0]      last_idx_q;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      retire_cnt;
  logic [WC_W-1:0]       wload_cnt;
  logic [PIPE_DEPTH-1:0] vld_sr;

  logic accept;
  logic issue;
  logic last_issue;
  logic drain_empty;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // ------------------------------------------------------------------
  // Next state and control strobes
  // ------------------------------------------------------------------
  always_comb begin
    nxt_state   = cur_state;
    accept      = 1'b0;
    issue       = 1'b0;
    last_issue  = 1'b0;
    w_rd        = 1'b0;
    busy        = 1'b1;
    // The pipeline bit that is about to fall off the end is the only one
    // allowed to be set: the edge that retires it also leaves DRAIN.
    drain_empty = (vld_sr[PIPE_DEPTH-2:0] == '0);

    unique case (cur_state)
      S_IDLE: begin
        busy = 1'b0;
        // Gated with reset so acc_clear stays low while reset is held.
        accept = start & ~reset;
        if (accept) begin
          nxt_state = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        w_rd = 1'b1;
        if (wload_cnt == W_LAST) begin
          nxt_state = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        // A bubble (in_valid low) neither issues nor stalls the pipeline.
        issue      = in_valid;
        last_issue = in_valid & (issue_cnt == last_idx_q);
        if (last_issue) begin
          nxt_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_empty) begin
          nxt_state = S_IDLE;
        end
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Config latches, counters and the valid shift register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bw_q       <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      last_idx_q <= '0;
      issue_cnt  <= '0;
      retire_cnt <= '0;
      wload_cnt  <= '0;
      vld_sr     <= '0;
    end else begin
      // Shifted every cycle in every state; bit 0 captures this cycle's issue.
      vld_sr <= {vld_sr[PIPE_DEPTH-2:0], issue};

      if (accept) begin
        bw_q       <= cfg_bitwidth;
        sx_q       <= cfg_sign_x;
        sy_q       <= cfg_sign_y;
        last_idx_q <= (cfg_num_vec == '0) ? '0 : (cfg_num_vec - CNT_W'(1));
        issue_cnt  <= '0;
        retire_cnt <= '0;
        wload_cnt  <= '0;
      end else begin
        if (cur_state == S_LOAD_W) begin
          wload_cnt <= wload_cnt + WC_W'(1);
        end
        if (issue) begin
          issue_cnt <= issue_cnt + CNT_W'(1);
        end
        if (out_valid) begin
          retire_cnt <= retire_cnt + CNT_W'(1);
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign in_rd          = issue;
  assign acc_clear      = accept;
  assign state          = cur_state;
  assign input_bitwidth = bw_q;
  assign sign_x         = sx_q;
  assign sign_y         = sy_q;
  assign out_valid      = vld_sr[PIPE_DEPTH-1];
  assign done           = out_valid & (retire_cnt == last_idx_q);

  always_comb begin
    signal = SIG_8B;
    case (bw_q)
      2'b00:   signal = SIG_2B;
      2'b01:   signal = SIG_4B;
      default: signal = SIG_8B;
    endcase
  end

endmodule

// File: tb/tb_bitfusion_column_ctrl.sv
// Testbench for bitfusion_column_ctrl: table-driven jobs, hand-written reset
// and back-to-back sequences, and randomized jobs, all checked every cycle
// against a job-timeline reference model.
module tb_bitfusion_column_ctrl;

  localparam int          PIPE = 20;
  localparam int          WLD  = 2;
  localparam logic [63:0] S2   = 64'h0202_0202_0202_0202;
  localparam logic [63:0] S4   = 64'h0404_0404_0404_0404;
  localparam logic [63:0] S8   = 64'h0808_0808_0808_0808;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  cfg_bitwidth;
  logic [3:0]  cfg_sign_x;
  logic [3:0]  cfg_sign_y;
  logic [15:0] cfg_num_vec;
  logic        in_valid;
  logic        in_rd;
  logic        w_rd;
  logic        acc_clear;
  logic [1:0]  state;
  logic [1:0]  input_bitwidth;
  logic [3:0]  sign_x;
  logic [3:0]  sign_y;
  logic [63:0] signal;
  logic        out_valid;
  logic        busy;
  logic        done;

  bitfusion_column_ctrl #(
    .PIPE_DEPTH(PIPE), .WLOAD_CYC(WLD), .CNT_W(16),
    .SIG_2B(S2), .SIG_4B(S4), .SIG_8B(S8)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_bitwidth(cfg_bitwidth), .cfg_sign_x(cfg_sign_x), .cfg_sign_y(cfg_sign_y),
    .cfg_num_vec(cfg_num_vec), .in_valid(in_valid),
    .in_rd(in_rd), .w_rd(w_rd), .acc_clear(acc_clear), .state(state),
    .input_bitwidth(input_bitwidth), .sign_x(sign_x), .sign_y(sign_y),
    .signal(signal), .out_valid(out_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @t=%0t: got %h, required %h", name, $time, act, exp);
  endtask

  // ---------------- reference model: job timeline ----------------
  int          m_cyc;
  bit          m_active;
  int          m_start;
  int          m_n;
  int          m_issued;
  int          m_retired;
  logic [1:0]  m_bw;
  logic [3:0]  m_sx;
  logic [3:0]  m_sy;
  int          m_outq[$];   // absolute cycles at which an out_valid is due

  logic obs_out, obs_done, obs_busy, obs_acc;

  function automatic logic [63:0] sig_of(input logic [1:0] bw);
    return (bw == 2'b00) ? S2 : (bw == 2'b01) ? S4 : S8;
  endfunction

  task automatic model_reset();
    m_active = 0; m_bw = '0; m_sx = '0; m_sy = '0;
    m_issued = 0; m_retired = 0; m_n = 0;
    m_outq.delete();
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input logic st, input logic [1:0] bw, input logic [3:0] sx,
                      input logic [3:0] sy, input logic [15:0] nv, input logic iv);
    logic [1:0] e_state;
    logic       e_in_rd, e_out, e_done, e_acc;
    @(negedge clk);
    start = st; cfg_bitwidth = bw; cfg_sign_x = sx; cfg_sign_y = sy;
    cfg_num_vec = nv; in_valid = iv;
    #1;
    if (!m_active)                    e_state = 2'b00;
    else if (m_cyc <= m_start + WLD)  e_state = 2'b01;
    else if (m_issued < m_n)          e_state = 2'b10;
    else                              e_state = 2'b11;
    e_in_rd = (e_state == 2'b10) && iv;
    e_acc   = !m_active && st;
    e_out   = (m_outq.size() > 0) && (m_outq[0] == m_cyc);
    e_done  = e_out && (m_retired + 1 == m_n);
    chk("state", 64'(state), 64'(e_state));
    chk("busy", 64'(busy), 64'(m_active));
    chk("in_rd", 64'(in_rd), 64'(e_in_rd));
    chk("w_rd", 64'(w_rd), 64'(e_state == 2'b01));
    chk("acc_clear", 64'(acc_clear), 64'(e_acc));
    chk("out_valid", 64'(out_valid), 64'(e_out));
    chk("done", 64'(done), 64'(e_done));
    chk("input_bitwidth", 64'(input_bitwidth), 64'(m_bw));
    chk("sign_x", 64'(sign_x), 64'(m_sx));
    chk("sign_y", 64'(sign_y), 64'(m_sy));
    chk("signal", signal, sig_of(m_bw));
    obs_out = out_valid; obs_done = done; obs_busy = busy; obs_acc = acc_clear;
    @(posedge clk);
    if (e_out) begin
      void'(m_outq.pop_front());
      m_retired++;
      if (e_done) m_active = 0;
    end
    if (e_in_rd) begin
      m_outq.push_back(m_cyc + PIPE);
      m_issued++;
    end
    if (e_acc) begin
      m_active = 1; m_start = m_cyc;
      m_bw = bw; m_sx = sx; m_sy = sy;
      m_n = (nv == 0) ? 1 : int'(nv);
      m_issued = 0; m_retired = 0;
    end
    m_cyc++;
  endtask

  // ---------------- table of jobs ----------------
  typedef struct {
    logic [15:0] nv;
    logic [1:0]  bw;
    logic [3:0]  sx;
    logic [3:0]  sy;
    logic [31:0] vpat;      // in_valid per cycle after acceptance (bit k), 1 beyond vlen
    int          vlen;
    bit          junk;      // pulse start with changed cfg while busy
    int          exp_outs;
    int          exp_busy;
    logic [63:0] exp_sig;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_out, n_done, n_busy, k;
    logic iv;
    m_cyc = 0;
    model_reset();
    reset = 1'b1; start = 1'b0; cfg_bitwidth = '0; cfg_sign_x = '0;
    cfg_sign_y = '0; cfg_num_vec = '0; in_valid = 1'b0;
    #1;
    chk("rst state", 64'(state), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst signal", signal, S2);
    chk("rst done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    //                nv   bw     sx    sy    vpat   vlen junk outs busy sig
    tbl[0] = '{16'd4, 2'b00, 4'h0, 4'h0, 32'h0,  0,   0,   4,  26, S2}; // basic
    tbl[1] = '{16'd3, 2'b11, 4'h1, 4'h2, 32'h67, 7,   0,   3,  27, S8}; // bubbles 1,0,0,1,1
    tbl[2] = '{16'd5, 2'b01, 4'hA, 4'h5, 32'h0,  0,   1,   5,  27, S4}; // ignored cfg/start
    tbl[3] = '{16'd0, 2'b10, 4'h7, 4'h9, 32'h0,  0,   0,   1,  23, S8}; // num_vec 0
    tbl[4] = '{16'd2, 2'b00, 4'h3, 4'hC, 32'h28, 6,   0,   2,  26, S2}; // bubbles in LOAD_W
    tbl[5] = '{16'd1, 2'b01, 4'hF, 4'hE, 32'h0,  0,   0,   1,  23, S4}; // single; back-to-back

    // Each job starts in the first IDLE cycle after the previous one.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, tbl[i].bw, tbl[i].sx, tbl[i].sy, tbl[i].nv, 1'b0);
      chk($sformatf("tbl%0d acc_clear", i), 64'(obs_acc), 64'd1);
      n_out = 0; n_done = 0; n_busy = 0; k = 0;
      while (m_active && k < 300) begin
        iv = (k < tbl[i].vlen) ? tbl[i].vpat[k] : 1'b1;
        if (tbl[i].junk)
          step(1'b1, 2'b11, 4'h5, 4'h3, 16'd9, iv);
        else
          step(1'b0, tbl[i].bw, tbl[i].sx, tbl[i].sy, tbl[i].nv, iv);
        if (k == 0) begin
          chk($sformatf("tbl%0d signal", i), signal, tbl[i].exp_sig);
          chk($sformatf("tbl%0d sign_x", i), 64'(sign_x), 64'(tbl[i].sx));
        end
        n_out += int'(obs_out); n_done += int'(obs_done); n_busy += int'(obs_busy);
        k++;
      end
      chk($sformatf("tbl%0d finished", i), 64'(k < 300), 64'd1);
      chk($sformatf("tbl%0d out count", i), 64'(n_out), 64'(tbl[i].exp_outs));
      chk($sformatf("tbl%0d done count", i), 64'(n_done), 64'd1);
      chk($sformatf("tbl%0d busy cycles", i), 64'(n_busy), 64'(tbl[i].exp_busy));
    end

    // Reset mid-COMPUTE while out_valid is high: must clear before any edge.
    step(1'b1, 2'b10, 4'h3, 4'hC, 16'd40, 1'b1);
    repeat (26) step(1'b0, 2'b10, 4'h3, 4'hC, 16'd40, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; start = 1'b0;
    #1;
    chk("pre-reset out_valid", 64'(out_valid), 64'd1);
    chk("pre-reset state", 64'(state), 64'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("async state", 64'(state), 64'd0);
    chk("async busy", 64'(busy), 64'd0);
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async in_rd", 64'(in_rd), 64'd0);
    chk("async signal", signal, S2);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    m_cyc++;
    // No stale out_valid may surface after the reset.
    repeat (25) step(1'b0, 2'b00, 4'h0, 4'h0, 16'd0, 1'b1);

    // Randomized jobs with bubbles, idle gaps and ignored starts.
    for (int j = 0; j < 40; j++) begin
      repeat ($urandom_range(0, 2))
        step(1'b0, 2'($urandom), 4'($urandom), 4'($urandom), 16'($urandom), 1'($urandom));
      step(1'b1, 2'($urandom), 4'($urandom), 4'($urandom),
           16'($urandom_range(0, 12)), 1'($urandom));
      k = 0;
      while (m_active && k < 400) begin
        step(1'($urandom_range(0, 3) == 0), 2'($urandom), 4'($urandom), 4'($urandom),
             16'($urandom), 1'($urandom_range(0, 9) < 7));
        k++;
      end
      chk($sformatf("rand%0d finished", j), 64'(k < 400), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
